// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and walk-length helper for the register-file dump engine.
// Optional feature: REGFILE_DUMP_SKIPZERO_EN excludes x0 from the walk.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);
  localparam int XLEN       = 32;
  localparam int CNT_W      = REG_ADDR_W + 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      reg_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } dump_state_e;

  // Number of beats a walk first..last (inclusive, wrapping) will emit.
  function automatic reg_cnt_t walk_len(input reg_addr_t first, input reg_addr_t last);
    reg_addr_t span;
    reg_cnt_t  len;
`ifdef REGFILE_DUMP_SKIPZERO_EN
    reg_addr_t to_zero;
`endif
    span = last - first;
    len  = reg_cnt_t'(span) + reg_cnt_t'(1);
`ifdef REGFILE_DUMP_SKIPZERO_EN
    // x0 lies in the range when the distance from first to 0 fits inside the span.
    to_zero = reg_addr_t'(0) - first;
    if (to_zero <= span) len = len - reg_cnt_t'(1);
`endif
    return len;
  endfunction

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry valid/ready output register for the dump stream: a load overwrites the entry,
// an accepted beat without a new load empties it.
module dump_out_reg
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            ready_i,
  input  logic [XLEN-1:0] data_i,
  input  reg_addr_t       addr_i,
  input  logic            last_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output reg_addr_t       addr_o,
  output logic            last_o
);

  logic            valid_q;
  logic [XLEN-1:0] data_q;
  reg_addr_t       addr_q;
  logic            last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks x[first_reg]..x[last_reg] (wrapping) through one regfile read
// port and streams each value over valid/ready. Optional REGFILE_DUMP_SKIPZERO_EN skips x0.
module regfile_dump
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  reg_addr_t       first_reg,
  input  reg_addr_t       last_reg,
  output reg_addr_t       rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output reg_addr_t       out_addr,
  output logic            out_last,
  output logic            done
);

  dump_state_e state_q, state_d;
  reg_addr_t   addr_q, addr_d;
  reg_cnt_t    remain_q, remain_d;
  logic        out_free;
  logic        have_work;
  logic        skip_zero;
  logic        load_beat;

  // The output slot can take a new beat when it is empty or being drained this cycle.
  assign out_free  = !out_valid || out_ready;
  assign have_work = (remain_q != '0);

`ifdef REGFILE_DUMP_SKIPZERO_EN
  assign skip_zero = (addr_q == '0);
`else
  assign skip_zero = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    load_beat = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = first_reg;
          remain_d = walk_len(first_reg, last_reg);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (have_work) begin
          if (out_free) begin
            addr_d = addr_q + reg_addr_t'(1);
            if (!skip_zero) begin
              load_beat = 1'b1;
              remain_d  = remain_q - reg_cnt_t'(1);
            end
          end
        end else if (out_free) begin
          // Final beat accepted (or nothing was ever loaded): wrap up.
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  dump_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_beat),
    .ready_i (out_ready),
    .data_i  (rd_data),
    .addr_i  (addr_q),
    .last_i  (remain_q == reg_cnt_t'(1)),
    .valid_o (out_valid),
    .data_o  (out_data),
    .addr_o  (out_addr),
    .last_o  (out_last)
  );

  assign rd_addr = addr_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_FINISH);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven walks plus full-dump and mid-dump reset sequences.
module tb_regfile_dump;
  import regfile_pkg::*;

`ifdef REGFILE_DUMP_SKIPZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [4:0]      first_reg = '0;
  logic [4:0]      last_reg = '0;
  logic [4:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            busy;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_data;
  logic [4:0]      out_addr;
  logic            out_last;
  logic            done;

  logic [31:0] rf [32];
  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf_val(input int i);
    return (i == 2) ? 32'h3FC : 32'h11 * i;
  endfunction

  // Capture of one dump, filled by run_dump.
  logic [4:0]  cap_a [64];
  logic [31:0] cap_d [64];
  logic        cap_l [64];
  int cap_n, cap_stalls, cap_viol, cap_done_len, cap_done_c, cap_hs_c, cap_first_c;
  logic cap_busy0, cap_busy_after, cap_timeout;

  // Start a dump, drive out_ready from rpat[cycle], record beats until done falls.
  // With poke set, start is re-asserted while busy and during the done cycle.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input logic [31:0] rpat,
                          input bit poke);
    logic [4:0]  h_a, h_ra;
    logic [31:0] h_d;
    logic        h_l;
    bit          held, fin;
    cap_n = 0; cap_stalls = 0; cap_viol = 0; cap_done_len = 0;
    cap_done_c = -1; cap_hs_c = -1; cap_first_c = -1;
    cap_busy0 = 1'b0; cap_busy_after = 1'b1; cap_timeout = 1'b0;
    held = 1'b0; fin = 1'b0;
    h_a = '0; h_ra = '0; h_d = '0; h_l = 1'b0;
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (c < 32) ? rpat[c] : 1'b1;
      if (c == 0) cap_busy0 = busy;
      if (poke && c == 1) begin start = 1'b1; first_reg = 5'd10; last_reg = 5'd12; end
      if (held && {out_addr, out_data, out_last, rd_addr} != {h_a, h_d, h_l, h_ra}) cap_viol++;
      held = 1'b0;
      if (out_valid && cap_first_c < 0) cap_first_c = c;
      if (out_valid && out_ready) begin
        if (cap_n < 64) begin
          cap_a[cap_n] = out_addr; cap_d[cap_n] = out_data; cap_l[cap_n] = out_last;
        end
        cap_n++;
        cap_hs_c = c;
      end else if (out_valid) begin
        cap_stalls++;
        held = 1'b1;
        h_a = out_addr; h_d = out_data; h_l = out_last; h_ra = rd_addr;
      end
      if (done) begin
        cap_done_len++;
        if (cap_done_c < 0) cap_done_c = c;
        if (poke) start = 1'b1;
      end else if (cap_done_c >= 0) begin
        cap_busy_after = busy;
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!fin) cap_timeout = 1'b1;
  endtask

  typedef struct {
    string            name;
    logic [4:0]       first;
    logic [4:0]       last;
    logic [31:0]      rpat;
    int               n;
    logic [0:3][4:0]  a;
    logic [0:3][31:0] d;
    int               stalls;
    bit               poke;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"backpressure", 5'd4, 5'd6, 32'hFFFF_FFF3, 3,
                '{5'd4, 5'd5, 5'd6, 5'd0}, '{32'h44, 32'h55, 32'h66, 32'h0}, 2, 1'b0};
`ifdef REGFILE_DUMP_SKIPZERO_EN
    vecs[1] = '{"wrap", 5'd30, 5'd1, 32'hFFFF_FFFF, 3,
                '{5'd30, 5'd31, 5'd1, 5'd0}, '{32'h1FE, 32'h20F, 32'h11, 32'h0}, 0, 1'b0};
    vecs[3] = '{"low_range", 5'd0, 5'd3, 32'hFFFF_FFFF, 3,
                '{5'd1, 5'd2, 5'd3, 5'd0}, '{32'h11, 32'h3FC, 32'h33, 32'h0}, 0, 1'b0};
    vecs[4] = '{"only_x0", 5'd0, 5'd0, 32'hFFFF_FFFF, 0,
                '{5'd0, 5'd0, 5'd0, 5'd0}, '{32'h0, 32'h0, 32'h0, 32'h0}, 0, 1'b0};
`else
    vecs[1] = '{"wrap", 5'd30, 5'd1, 32'hFFFF_FFFF, 4,
                '{5'd30, 5'd31, 5'd0, 5'd1}, '{32'h1FE, 32'h20F, 32'h0, 32'h11}, 0, 1'b0};
    vecs[3] = '{"low_range", 5'd0, 5'd3, 32'hFFFF_FFFF, 4,
                '{5'd0, 5'd1, 5'd2, 5'd3}, '{32'h0, 32'h11, 32'h3FC, 32'h33}, 0, 1'b0};
    vecs[4] = '{"single_x31", 5'd31, 5'd31, 32'hFFFF_FFFF, 1,
                '{5'd31, 5'd0, 5'd0, 5'd0}, '{32'h20F, 32'h0, 32'h0, 32'h0}, 0, 1'b0};
`endif
    vecs[2] = '{"single_x2", 5'd2, 5'd2, 32'hFFFF_FFFF, 1,
                '{5'd2, 5'd0, 5'd0, 5'd0}, '{32'h3FC, 32'h0, 32'h0, 32'h0}, 0, 1'b1};

    for (int i = 0; i < 32; i++) rf[i] = rf_val(i);

    // Asynchronous reset state.
    #1 reset = 1'b0;
    #2;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst out_last", out_last, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst out_data", out_data, 0);
    check("rst out_addr", out_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Full dump 0..31, always ready.
    run_dump(5'd0, 5'd31, 32'hFFFF_FFFF, 1'b0);
    check("full timeout", cap_timeout, 0);
    check("full beats", cap_n, SKIP ? 31 : 32);
    for (int k = 0; k < cap_n && k < 32; k++) begin
      int ea;
      ea = SKIP ? k + 1 : k;
      check($sformatf("full addr[%0d]", k), cap_a[k], ea);
      check($sformatf("full data[%0d]", k), cap_d[k], rf_val(ea));
      check($sformatf("full last[%0d]", k), cap_l[k], (ea == 31) ? 1 : 0);
    end
    check("full first valid cycle", cap_first_c, SKIP ? 2 : 1);
    check("full contiguous beats", cap_hs_c - cap_first_c + 1, cap_n);
    check("full done cycle", cap_done_c, cap_hs_c + 1);
    check("full done width", cap_done_len, 1);
    check("full busy after", cap_busy_after, 0);

    // Table-driven walks.
    for (int v = 0; v < 5; v++) begin
      int exp_done_c;
      run_dump(vecs[v].first, vecs[v].last, vecs[v].rpat, vecs[v].poke);
      check({vecs[v].name, " timeout"}, cap_timeout, 0);
      check({vecs[v].name, " beats"}, cap_n, vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < cap_n && k < 4; k++) begin
        check($sformatf("%s addr[%0d]", vecs[v].name, k), cap_a[k], vecs[v].a[k]);
        check($sformatf("%s data[%0d]", vecs[v].name, k), cap_d[k], vecs[v].d[k]);
        check($sformatf("%s last[%0d]", vecs[v].name, k), cap_l[k], (k == vecs[v].n - 1) ? 1 : 0);
      end
      check({vecs[v].name, " stalls"}, cap_stalls, vecs[v].stalls);
      check({vecs[v].name, " stall hold"}, cap_viol, 0);
      check({vecs[v].name, " busy at start"}, cap_busy0, 1);
      exp_done_c = (vecs[v].n > 0) ? cap_hs_c + 1 : 1;
      check({vecs[v].name, " done cycle"}, cap_done_c, exp_done_c);
      check({vecs[v].name, " done width"}, cap_done_len, 1);
      check({vecs[v].name, " busy after"}, cap_busy_after, 0);
      if (vecs[v].n > 0)
        check({vecs[v].name, " first valid cycle"}, cap_first_c,
              (SKIP && vecs[v].first == 5'd0) ? 2 : 1);
      if (vecs[v].poke) begin
        int extra;
        extra = 0;
        repeat (4) begin
          @(negedge clk);
          if (out_valid || busy || done) extra++;
        end
        check({vecs[v].name, " ignored restart"}, extra, 0);
      end
    end

    // Reset asserted mid-dump, between clock edges.
    @(negedge clk);
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-abort busy", busy, 1);
    check("pre-abort out_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort rd_addr", rd_addr, 0);
    check("abort out_addr", out_addr, 0);
    @(negedge clk);
    check("abort no done", done, 0);
    reset = 1'b1;
    run_dump(5'd5, 5'd7, 32'hFFFF_FFFF, 1'b0);
    check("post-abort timeout", cap_timeout, 0);
    check("post-abort beats", cap_n, 3);
    for (int k = 0; k < 3 && k < cap_n; k++) begin
      check($sformatf("post-abort addr[%0d]", k), cap_a[k], 5 + k);
      check($sformatf("post-abort data[%0d]", k), cap_d[k], 32'h55 + 32'h11 * k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
